// File: rtl/snake_pkg.sv
// Shared constants for the snake game: board geometry, pixel mapping and the
// food-spawn FSM encoding.
package snake_pkg;

  localparam int          DFLT_LFSR_W    = 32;
  localparam logic [31:0] DFLT_TAPS      = 32'h8020_0003;
  localparam logic [31:0] DFLT_SEED      = 32'hACE1_5EED;

  localparam int          DFLT_GRID_W    = 30;
  localparam int          DFLT_GRID_H    = 30;
  localparam int          DFLT_IDX_W     = 5;

  localparam int          DFLT_X_SCALE   = 2;
  localparam int          DFLT_X_OFF     = 18;
  localparam int          DFLT_Y_SCALE   = 2;
  localparam int          DFLT_Y_OFF     = 2;
  localparam int          DFLT_COORD_W   = 7;

  localparam int          DFLT_MAX_TRIES = 16;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_DRAW  = 3'd1,
    S_QUERY = 3'd2,
    S_SCAN  = 3'd3,
    S_DONE  = 3'd4,
    S_FULL  = 3'd5
  } spawn_state_t;

endpackage

// File: rtl/galois_lfsr.sv
// Free-running right-shift Galois LFSR with synchronous seed load.
// A zero seed (parameter or port) is replaced by 1 so the register never locks up.
module galois_lfsr #(
  parameter int                LFSR_W = 32,
  parameter logic [LFSR_W-1:0] TAPS   = LFSR_W'(32'h8020_0003),
  parameter logic [LFSR_W-1:0] SEED   = LFSR_W'(32'hACE1_5EED)
) (
  input  logic              CLOCK,
  input  logic              RESETN,
  input  logic              load,
  input  logic [LFSR_W-1:0] seed,
  output logic [LFSR_W-1:0] q
);

  localparam logic [LFSR_W-1:0] ONE     = LFSR_W'(1);
  localparam logic [LFSR_W-1:0] SEED_NZ = (SEED == '0) ? ONE : SEED;

  logic [LFSR_W-1:0] step;

  assign step = {1'b0, q[LFSR_W-1:1]} ^ (q[0] ? TAPS : '0);

  always_ff @(posedge CLOCK or negedge RESETN) begin
    if (!RESETN)
      q <= SEED_NZ;
    else if (load)
      q <= (seed == '0) ? ONE : seed;
    else
      q <= step;
  end

endmodule

// File: rtl/food_spawner.sv
// Picks a free board cell for the next food item: random draws checked against the
// body tracker, falling back to a linear sweep, with a sticky board-full flag.
module food_spawner
  import snake_pkg::*;
#(
  parameter int                LFSR_W    = DFLT_LFSR_W,
  parameter logic [LFSR_W-1:0] TAPS      = LFSR_W'(DFLT_TAPS),
  parameter logic [LFSR_W-1:0] SEED      = LFSR_W'(DFLT_SEED),
  parameter int                GRID_W    = DFLT_GRID_W,
  parameter int                GRID_H    = DFLT_GRID_H,
  parameter int                IDX_W     = DFLT_IDX_W,
  parameter int                X_SCALE   = DFLT_X_SCALE,
  parameter int                X_OFF     = DFLT_X_OFF,
  parameter int                Y_SCALE   = DFLT_Y_SCALE,
  parameter int                Y_OFF     = DFLT_Y_OFF,
  parameter int                COORD_W   = DFLT_COORD_W,
  parameter int                MAX_TRIES = DFLT_MAX_TRIES
) (
  input  logic               CLOCK,
  input  logic               RESETN,
  input  logic               start,
  input  logic               eat,
  input  logic               seed_load,
  input  logic [LFSR_W-1:0]  seed,
  output logic               occ_req,
  output logic [IDX_W-1:0]   occ_cx,
  output logic [IDX_W-1:0]   occ_cy,
  input  logic               occ_ack,
  input  logic               occ_hit,
  output logic [COORD_W-1:0] x,
  output logic [COORD_W-1:0] y,
  output logic               food_valid,
  output logic               busy,
  output logic               board_full
);

  localparam int CELLS  = GRID_W * GRID_H;
  localparam int TRY_W  = $clog2(MAX_TRIES + 1);
  localparam int SCAN_W = $clog2(CELLS + 1);

  localparam logic [IDX_W:0]       GW      = (IDX_W+1)'(GRID_W);
  localparam logic [IDX_W:0]       GH      = (IDX_W+1)'(GRID_H);
  localparam logic [IDX_W:0]       GW_LAST = (IDX_W+1)'(GRID_W - 1);
  localparam logic [IDX_W:0]       GH_LAST = (IDX_W+1)'(GRID_H - 1);
  localparam logic [TRY_W-1:0]     TRY_LIM = TRY_W'(MAX_TRIES);
  localparam logic [SCAN_W-1:0]    SCAN_LIM = SCAN_W'(CELLS - 1);
  localparam logic [COORD_W-1:0]   XO      = COORD_W'(X_OFF);
  localparam logic [COORD_W-1:0]   YO      = COORD_W'(Y_OFF);
  localparam logic [COORD_W-1:0]   XS      = COORD_W'(X_SCALE);
  localparam logic [COORD_W-1:0]   YS      = COORD_W'(Y_SCALE);

  // Elaboration-time parameter sanity: the far corner must map inside COORD_W.
  if (LFSR_W < 2*IDX_W) begin : g_bad_lfsr_w
    $error("food_spawner: LFSR_W too narrow for two cell indices");
  end
  if ((2**IDX_W < GRID_W) || (2**IDX_W < GRID_H)) begin : g_bad_idx_w
    $error("food_spawner: IDX_W too narrow for the grid");
  end
  if ((GRID_W-1)*X_SCALE + X_OFF >= 2**COORD_W) begin : g_bad_x_range
    $error("food_spawner: x coordinate overflows COORD_W");
  end
  if ((GRID_H-1)*Y_SCALE + Y_OFF >= 2**COORD_W) begin : g_bad_y_range
    $error("food_spawner: y coordinate overflows COORD_W");
  end

  spawn_state_t        state;
  logic [LFSR_W-1:0]   lfsr_q;
  logic [IDX_W-1:0]    cand_cx, cand_cy;
  logic                cand_ok;
  logic [TRY_W-1:0]    tries;
  logic [SCAN_W-1:0]   scan_cnt;
  logic                have_cell;
  logic [IDX_W-1:0]    nx, ny;
  logic [COORD_W-1:0]  px, py;
  logic                unused_lfsr;

  galois_lfsr #(
    .LFSR_W (LFSR_W),
    .TAPS   (TAPS),
    .SEED   (SEED)
  ) u_lfsr (
    .CLOCK  (CLOCK),
    .RESETN (RESETN),
    .load   (seed_load),
    .seed   (seed),
    .q      (lfsr_q)
  );

  assign cand_cx     = lfsr_q[IDX_W-1:0];
  assign cand_cy     = lfsr_q[2*IDX_W-1:IDX_W];
  assign cand_ok     = ({1'b0, cand_cx} < GW) && ({1'b0, cand_cy} < GH);
  assign unused_lfsr = ^lfsr_q[LFSR_W-1:2*IDX_W];

  // Raster-order successor of the cell currently on the query port.
  always_comb begin
    nx = occ_cx + 1'b1;
    ny = occ_cy;
    if ({1'b0, occ_cx} == GW_LAST) begin
      nx = '0;
      ny = ({1'b0, occ_cy} == GH_LAST) ? '0 : occ_cy + 1'b1;
    end
  end

  assign px = COORD_W'(occ_cx) * XS + XO;
  assign py = COORD_W'(occ_cy) * YS + YO;

  // occ_cx/occ_cy double as the latched candidate and the final result cell.
  always_ff @(posedge CLOCK or negedge RESETN) begin
    if (!RESETN) begin
      state      <= S_IDLE;
      tries      <= '0;
      scan_cnt   <= '0;
      have_cell  <= 1'b0;
      occ_req    <= 1'b0;
      occ_cx     <= '0;
      occ_cy     <= '0;
      x          <= XO;
      y          <= YO;
      food_valid <= 1'b0;
      busy       <= 1'b0;
      board_full <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start || eat) begin
            state      <= S_DRAW;
            busy       <= 1'b1;
            food_valid <= 1'b0;
            board_full <= 1'b0;
            tries      <= '0;
            have_cell  <= 1'b0;
          end
        end

        S_DRAW: begin
          if (tries == TRY_LIM) begin
            state    <= S_SCAN;
            occ_req  <= 1'b1;
            scan_cnt <= '0;
            if (!have_cell) begin
              occ_cx <= '0;
              occ_cy <= '0;
            end
          end else if (!cand_ok) begin
            tries <= tries + 1'b1;
          end else begin
            occ_cx    <= cand_cx;
            occ_cy    <= cand_cy;
            have_cell <= 1'b1;
            occ_req   <= 1'b1;
            state     <= S_QUERY;
          end
        end

        S_QUERY: begin
          if (occ_ack) begin
            occ_req <= 1'b0;
            if (occ_hit) begin
              tries <= tries + 1'b1;
              state <= S_DRAW;
            end else begin
              state <= S_DONE;
            end
          end
        end

        S_SCAN: begin
          if (occ_ack) begin
            if (!occ_hit) begin
              occ_req <= 1'b0;
              state   <= S_DONE;
            end else if (scan_cnt == SCAN_LIM) begin
              occ_req <= 1'b0;
              state   <= S_FULL;
            end else begin
              scan_cnt <= scan_cnt + 1'b1;
              occ_cx   <= nx;
              occ_cy   <= ny;
            end
          end
        end

        S_DONE: begin
          x          <= px;
          y          <= py;
          food_valid <= 1'b1;
          busy       <= 1'b0;
          state      <= S_IDLE;
        end

        S_FULL: begin
          board_full <= 1'b1;
          busy       <= 1'b0;
          state      <= S_IDLE;
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
